// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - registered ALU operand select with forwarding, load-use stall and stall counter
//
// Purpose:
//   Selects the A/B ALU operands for each instruction from the register file
//   (forwarded from EX/WB), PC+1, the constant unit, the D register or zero,
//   and holds them in a valid/ready pipeline register. Load-use hazards block
//   acceptance and are counted in a saturating counter.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake (in_ready is combinational)
//   flush               squashes the accepted input and any held output
//   selA/selB           operand selects
//   addrA/addrB         source register addresses
//   dataA/dataB/dataD   register-file read data
//   PC1                 PC+1 of the instruction
//   constant_unit       immediate
//   ex_*/wb_*           EX and WB write-back ports used for forwarding
//   out_valid/out_ready ALU-side handshake
//   busA/busB           registered operands
//   hazard_cnt          saturating count of load-use stall cycles

module operand_stage #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 10,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [1:0]        selA,
   input  logic [1:0]        selB,
   input  logic [REG_AW-1:0] addrA,
   input  logic [REG_AW-1:0] addrB,
   input  logic [DATA_W-1:0] dataA,
   input  logic [DATA_W-1:0] dataB,
   input  logic [DATA_W-1:0] dataD,
   input  logic [PC_W-1:0]   PC1,
   input  logic [DATA_W-1:0] constant_unit,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_wr_addr,
   input  logic [DATA_W-1:0] ex_wr_data,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_wr_addr,
   input  logic [DATA_W-1:0] wb_wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB,
   output logic [CNT_W-1:0]  hazard_cnt
);

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              load_hazard;
   logic              accept;

   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] bus_a_d, bus_a_q;
   logic [DATA_W-1:0] bus_b_d, bus_b_q;
   logic [CNT_W-1:0]  hazard_cnt_d, hazard_cnt_q;

   // Forwarding: EX is younger than WB so it wins; r0 is never forwarded.
   always_comb begin
      fwd_a = dataA;
      if (ex_wr_en && (ex_wr_addr == addrA) && (addrA != '0))
         fwd_a = ex_wr_data;
      else if (wb_wr_en && (wb_wr_addr == addrA) && (addrA != '0))
         fwd_a = wb_wr_data;

      fwd_b = dataB;
      if (ex_wr_en && (ex_wr_addr == addrB) && (addrB != '0))
         fwd_b = ex_wr_data;
      else if (wb_wr_en && (wb_wr_addr == addrB) && (addrB != '0))
         fwd_b = wb_wr_data;
   end

   always_comb begin
      op_a = '0;
      case (selA)
         2'b00:   op_a = fwd_a;
         2'b01:   op_a[PC_W-1:0] = PC1;
         2'b10:   op_a = dataD;
         default: op_a = '0;
      endcase

      op_b = '0;
      case (selB)
         2'b00:   op_b = fwd_b;
         2'b01:   op_b = constant_unit;
         2'b10:   op_b = dataD;
         default: op_b = '0;
      endcase
   end

   // A load in EX has no data yet, so a register operand that needs it must wait.
   always_comb begin
      load_hazard = in_valid && ex_wr_en && ex_is_load && (ex_wr_addr != '0) &&
                    (((selA == 2'b00) && (addrA == ex_wr_addr)) ||
                     ((selB == 2'b00) && (addrB == ex_wr_addr)));
      in_ready    = (!out_valid_q || out_ready) && !load_hazard;
      accept      = in_valid && in_ready && !flush;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      bus_a_d      = bus_a_q;
      bus_b_d      = bus_b_q;
      hazard_cnt_d = hazard_cnt_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         bus_a_d     = op_a;
         bus_b_d     = op_b;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (load_hazard && !flush && (hazard_cnt_q != '1))
         hazard_cnt_d = hazard_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         bus_a_q      <= '0;
         bus_b_q      <= '0;
         hazard_cnt_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         bus_a_q      <= bus_a_d;
         bus_b_q      <= bus_b_d;
         hazard_cnt_q <= hazard_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign busA       = bus_a_q;
   assign busB       = bus_b_q;
   assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - self-checking bench for operand_stage

module tb_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready, in_ready_s;
   logic        flush;
   logic [1:0]  selA, selB;
   logic [4:0]  addrA, addrB;
   logic [31:0] dataA, dataB, dataD;
   logic [9:0]  PC1;
   logic [31:0] constant_unit;
   logic        ex_wr_en, ex_is_load;
   logic [4:0]  ex_wr_addr;
   logic [31:0] ex_wr_data;
   logic        wb_wr_en;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        out_valid, out_valid_s;
   logic        out_ready;
   logic [31:0] busA, busB, busA_s, busB_s;
   logic [15:0] hazard_cnt;
   logic [1:0]  hazard_cnt_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   operand_stage #(.DATA_W(32), .PC_W(10), .REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .selA(selA), .selB(selB), .addrA(addrA), .addrB(addrB),
      .dataA(dataA), .dataB(dataB), .dataD(dataD), .PC1(PC1), .constant_unit(constant_unit),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .out_valid(out_valid), .out_ready(out_ready), .busA(busA), .busB(busB), .hazard_cnt(hazard_cnt)
   );

   operand_stage #(.DATA_W(32), .PC_W(10), .REG_AW(5), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .flush(flush),
      .selA(selA), .selB(selB), .addrA(addrA), .addrB(addrB),
      .dataA(dataA), .dataB(dataB), .dataD(dataD), .PC1(PC1), .constant_unit(constant_unit),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .busA(busA_s), .busB(busB_s), .hazard_cnt(hazard_cnt_s)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, actual still running, required finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic        m_valid;
   logic [31:0] m_a, m_b;
   int unsigned m_cnt, m_cnt_s;

   function automatic logic [31:0] ref_reg(input logic [4:0] a, input logic [31:0] d);
      if (a == 0) return d;
      if (ex_wr_en && ex_wr_addr == a) return ex_wr_data;
      if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
      return d;
   endfunction

   function automatic logic [31:0] ref_a();
      case (selA)
         2'd0: return ref_reg(addrA, dataA);
         2'd1: return 32'(PC1);
         2'd2: return dataD;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_b();
      case (selB)
         2'd0: return ref_reg(addrB, dataB);
         2'd1: return constant_unit;
         2'd2: return dataD;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit ref_hazard();
      bit uses;
      uses = (selA == 0 && addrA == ex_wr_addr) || (selB == 0 && addrB == ex_wr_addr);
      return in_valid && ex_wr_en && ex_is_load && ex_wr_addr != 0 && uses;
   endfunction

   task automatic clear_inputs();
      in_valid = 0; flush = 0; selA = 0; selB = 0; addrA = 0; addrB = 0;
      dataA = 0; dataB = 0; dataD = 0; PC1 = 0; constant_unit = 0;
      ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
      wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0; out_ready = 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 0;
      step();
      reset = 1;
      step();
      // create state: one hazard cycle then one accepted pair
      in_valid = 1; selB = 0; addrB = 3; selA = 2; dataD = 32'h55;
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3;
      step();
      ex_is_load = 0; ex_wr_en = 0; out_ready = 0;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || hazard_cnt !== 16'd1) begin
         n_bad++; $display("FAIL reset_setup: valid=%0b cnt=%0d required valid=1 cnt=1", out_valid, hazard_cnt);
      end
      #3 reset = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busA !== 32'd0 || busB !== 32'd0 || hazard_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_async: valid=%0b a=%h b=%h cnt=%0d required all 0", out_valid, busA, busB, hazard_cnt);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
      end
      #2 reset = 1;
      clear_inputs();
   endtask

   task automatic test_basic();
      in_valid = 1; selA = 1; PC1 = 10'h3FF; selB = 1; constant_unit = 32'h1234; out_ready = 1;
      step();
      n_cmp++;
      if (busA !== 32'h3FF || busB !== 32'h1234 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_pc_const: a=%h b=%h v=%0b required a=000003ff b=00001234 v=1", busA, busB, out_valid);
      end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      in_valid = 1; selA = 0; addrA = 5; dataA = 1; selB = 3;
      ex_wr_en = 1; ex_wr_addr = 5; ex_wr_data = 7;
      wb_wr_en = 1; wb_wr_addr = 5; wb_wr_data = 9;
      step();
      n_cmp++;
      if (busA !== 32'd7) begin n_bad++; $display("FAIL fwd_ex_priority: got %0d required 7", busA); end
      ex_wr_en = 0;
      step();
      n_cmp++;
      if (busA !== 32'd9) begin n_bad++; $display("FAIL fwd_wb: got %0d required 9", busA); end
      ex_wr_en = 1; addrA = 0; ex_wr_addr = 0; wb_wr_addr = 0;
      step();
      n_cmp++;
      if (busA !== 32'd1) begin n_bad++; $display("FAIL fwd_r0: got %0d required 1", busA); end
      // B side uses the same rule
      selB = 0; addrB = 6; dataB = 2; ex_wr_en = 0; wb_wr_addr = 6;
      step();
      n_cmp++;
      if (busB !== 32'd9) begin n_bad++; $display("FAIL fwd_b_wb: got %0d required 9", busB); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      clear_inputs();
      in_valid = 1; selA = 1; selB = 0; addrB = 3;
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_in_ready: got %0b required 0", in_ready); end
      step();
      n_cmp++;
      if (hazard_cnt !== 16'd1 || out_valid !== 1'b0) begin
         n_bad++; $display("FAIL hazard_count: cnt=%0d v=%0b required cnt=1 v=0", hazard_cnt, out_valid);
      end
      ex_is_load = 0; ex_wr_en = 0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_clear_ready: got %0b required 1", in_ready); end
      step();
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hazard_clear_accept: got %0b required 1", out_valid); end
      ex_wr_en = 1; ex_is_load = 1;
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (hazard_cnt_s !== 2'd3 || hazard_cnt !== 16'd6) begin
         n_bad++; $display("FAIL hazard_saturate: small=%0d main=%0d required small=3 main=6", hazard_cnt_s, hazard_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      step();
      out_ready = 0; in_valid = 1; selA = 2; selB = 1; dataD = 32'hA1; constant_unit = 32'hB1;
      step();
      dataD = 32'hA2; constant_unit = 32'hB2;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (in_ready !== 1'b0 || busA !== 32'hA1 || busB !== 32'hB1 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold: rdy=%0b a=%h b=%h v=%0b required rdy=0 a=a1 b=b1 v=1", in_ready, busA, busB, out_valid);
         end
         step();
      end
      out_ready = 1;
      step();
      n_cmp++;
      if (busA !== 32'hA2 || busB !== 32'hB2 || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL bp_second: a=%h b=%h v=%0b required a2 b2 1", busA, busB, out_valid);
      end
      dataD = 32'hA3; constant_unit = 32'hB3;
      step();
      n_cmp++;
      if (busA !== 32'hA3 || busB !== 32'hB3 || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL bp_third: a=%h b=%h v=%0b required a3 b3 1", busA, busB, out_valid);
      end
      in_valid = 0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %0b required 0", out_valid); end
   endtask

   task automatic test_flush();
      clear_inputs();
      in_valid = 1; selA = 2; dataD = 32'hC0FFEE;
      step();
      dataD = 32'h1111; flush = 1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %0b required 1", in_ready); end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || busA !== 32'hC0FFEE) begin
         n_bad++; $display("FAIL flush_accept: v=%0b a=%h required v=0 a=00c0ffee", out_valid, busA);
      end
      flush = 0; out_ready = 0; dataD = 32'h2222;
      step();
      in_valid = 0; flush = 1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || busA !== 32'h2222) begin
         n_bad++; $display("FAIL flush_held: v=%0b a=%h required v=0 a=00002222", out_valid, busA);
      end
      clear_inputs();
   endtask

   task automatic test_selects();
      clear_inputs();
      in_valid = 1; selA = 2; selB = 2; dataD = 32'hDEADBEEF;
      step();
      n_cmp++;
      if (busA !== 32'hDEADBEEF || busB !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL sel_d: a=%h b=%h required deadbeef", busA, busB);
      end
      selA = 3; selB = 3; dataA = 32'h5; dataB = 32'h6;
      step();
      n_cmp++;
      if (busA !== 32'd0 || busB !== 32'd0) begin
         n_bad++; $display("FAIL sel_zero: a=%h b=%h required 0", busA, busB);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      bit hz, rdy, acc;
      clear_inputs();
      reset = 0;
      #1;
      reset = 1;
      m_valid = 0; m_a = 0; m_b = 0; m_cnt = 0; m_cnt_s = 0;
      step();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         selA = 2'($urandom_range(0, 3)); selB = 2'($urandom_range(0, 3));
         addrA = 5'($urandom_range(0, 3)); addrB = 5'($urandom_range(0, 3));
         dataA = $urandom; dataB = $urandom; dataD = $urandom;
         PC1 = 10'($urandom); constant_unit = $urandom;
         ex_wr_en = $urandom_range(0, 1); ex_is_load = ($urandom_range(0, 3) == 0);
         ex_wr_addr = 5'($urandom_range(0, 3)); ex_wr_data = $urandom;
         wb_wr_en = $urandom_range(0, 1);
         wb_wr_addr = 5'($urandom_range(0, 3)); wb_wr_data = $urandom;
         #1;
         hz = ref_hazard();
         rdy = (!m_valid || out_ready) && !hz;
         acc = in_valid && rdy && !flush;
         n_cmp++;
         if (in_ready !== rdy) begin
            n_bad++; $display("FAIL rand_in_ready[%0d]: got %0b required %0b", i, in_ready, rdy);
         end
         if (flush) m_valid = 0;
         else if (acc) begin m_valid = 1; m_a = ref_a(); m_b = ref_b(); end
         else if (m_valid && out_ready) m_valid = 0;
         if (hz && !flush) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
         end
         step();
         n_cmp++;
         if (out_valid !== m_valid || busA !== m_a || busB !== m_b ||
             hazard_cnt !== 16'(m_cnt) || hazard_cnt_s !== 2'(m_cnt_s)) begin
            n_bad++;
            $display("FAIL rand_out[%0d]: v=%0b a=%h b=%h c=%0d cs=%0d required v=%0b a=%h b=%h c=%0d cs=%0d",
                     i, out_valid, busA, busB, hazard_cnt, hazard_cnt_s, m_valid, m_a, m_b, m_cnt, m_cnt_s);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      reset = 0;
      test_reset();
      test_basic();
      test_forwarding();
      test_load_use();
      test_back_to_back();
      test_flush();
      test_selects();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
